// File: rtl/div_unit.sv
// Iterative radix-2 restoring divide/remainder unit for RV32IM (DIV, DIVU, REM, REMU).
// One quotient bit per cycle; divide-by-zero and signed overflow finish in a single cycle.
module div_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [2:0]            op_type_i,
    input  logic [DATA_WIDTH-1:0] operand_a_i,
    input  logic [DATA_WIDTH-1:0] operand_b_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  done_o,
    output logic                  busy_o,
    output logic                  exception_valid_o,
    output logic [31:0]           exception_cause_o
);

    // state | meaning
    // IDLE  | waiting for start_i
    // CALC  | one restoring step per cycle, counter counts down to 0
    // DONE  | result_o valid, done_o high; a new start is accepted here
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = $clog2(W);
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  rem_q, quo_q, div_q, result_q;
    logic          is_rem_q, neg_q, done_q, busy_q;

    logic          is_signed, is_rem, a_neg, b_neg, div_zero, ovf, neg_res;
    logic [W-1:0]  a_abs, b_abs, special_res;
    logic [W+1:0]  sub;
    logic          borrow;
    logic [W-1:0]  rem_nxt, quo_nxt, fin, fin_res;
    logic [1:0]    unused_bits;

    assign unused_bits = {op_type_i[2], sub[W]};

    always_comb begin
        is_signed   = ~op_type_i[0];
        is_rem      = op_type_i[1];
        a_neg       = is_signed & operand_a_i[W-1];
        b_neg       = is_signed & operand_b_i[W-1];
        a_abs       = a_neg ? (~operand_a_i + 1'b1) : operand_a_i;
        b_abs       = b_neg ? (~operand_b_i + 1'b1) : operand_b_i;
        div_zero    = (operand_b_i == '0);
        ovf         = is_signed & (operand_a_i == MIN_NEG) & (operand_b_i == '1);
        neg_res     = is_rem ? a_neg : (a_neg ^ b_neg);
        special_res = div_zero ? (is_rem ? operand_a_i : '1)
                               : (is_rem ? '0 : MIN_NEG);

        // The shifted partial remainder needs W+1 bits when the divisor exceeds 2^(W-1).
        sub     = {1'b0, rem_q, quo_q[W-1]} - {2'b00, div_q};
        borrow  = sub[W+1];
        rem_nxt = borrow ? {rem_q[W-2:0], quo_q[W-1]} : sub[W-1:0];
        quo_nxt = {quo_q[W-2:0], ~borrow};
        fin     = is_rem_q ? rem_nxt : quo_nxt;
        fin_res = neg_q ? (~fin + 1'b1) : fin;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            result_q <= '0;
            is_rem_q <= 1'b0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        is_rem_q <= is_rem;
                        neg_q    <= neg_res;
                        div_q    <= b_abs;
                        if (div_zero || ovf) begin
                            result_q <= special_res;
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                        end else begin
                            rem_q   <= '0;
                            quo_q   <= a_abs;
                            cnt_q   <= CW'(W - 1);
                            state_q <= CALC;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    if (cnt_q == '0) begin
                        result_q <= fin_res;
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result_o          = result_q;
    assign done_o            = done_q;
    assign busy_o            = busy_q;
    assign exception_valid_o = 1'b0;
    assign exception_cause_o = '0;

`ifndef SYNTHESIS
    a_busy_done_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(busy_o && done_o));
    a_done_pulse: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (done_o && !start_i) |=> !done_o);
    a_no_exception: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !exception_valid_o);
`endif

endmodule

// File: tb/tb_div_unit.sv
// Directed and model-based checks for div_unit: results, latency, busy length,
// special cases, ignored mid-operation starts, back-to-back and async reset.
module tb_div_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  op_type_i = 3'b100;
    logic [31:0] operand_a_i = '0;
    logic [31:0] operand_b_i = '0;
    logic [31:0] result_o;
    logic        done_o, busy_o, exception_valid_o;
    logic [31:0] exception_cause_o;

    localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

    int n_checks = 0;
    int n_err    = 0;

    div_unit #(.DATA_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .op_type_i(op_type_i),
        .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .result_o(result_o),
        .done_o(done_o), .busy_o(busy_o), .exception_valid_o(exception_valid_o),
        .exception_cause_o(exception_cause_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issues start in the current cycle; returns result, latency (edges from E0 to done, E0 counted)
    // and busy cycle count. If pulse_at>0, a stray start with other operands is driven at that cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int pulse_at, output logic [31:0] res, output int lat,
                          output int nbusy);
        bit seen = 0;
        lat = 0;
        nbusy = 0;
        op_type_i = op; operand_a_i = a; operand_b_i = b; start_i = 1'b1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk_i); #1;
            start_i = 1'b0;
            lat++;
            if (busy_o) nbusy++;
            if (done_o) seen = 1;
            if (lat == pulse_at) begin
                start_i = 1'b1; operand_a_i = 32'd1000; operand_b_i = 32'd10;
            end
        end
        res = result_o;
        check("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic do_vec(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        logic [31:0] res;
        int lat, nbusy;
        run_op(op, a, b, 0, res, lat, nbusy);
        check({tag, " result"}, res, exp);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " busy_cycles"}, 32'(nbusy), (exp_lat == 33) ? 32'd32 : 32'd0);
        @(posedge clk_i); #1;
        check({tag, " held"}, result_o, exp);
        check({tag, " done_low"}, 32'(done_o), 32'd0);
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int sa, sb;
        sa = a; sb = b;
        case (op[1:0])
            2'b00: if (b == 0) return 32'hFFFF_FFFF;
                   else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                   else return 32'(sa / sb);
            2'b01: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10: if (b == 0) return a;
                   else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                   else return 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] res, a, b, exp;
        logic [2:0]  op;
        int lat, nbusy, n_done, exp_lat;

        #2;
        check("rst result", result_o, 32'd0);
        check("rst done", 32'(done_o), 32'd0);
        check("rst busy", 32'(busy_o), 32'd0);
        check("rst exc_valid", 32'(exception_valid_o), 32'd0);
        check("rst exc_cause", exception_cause_o, 32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(posedge clk_i); #1;

        do_vec("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        do_vec("remu 100/7", OP_REMU, 32'd100, 32'd7, 32'd2, 33);
        do_vec("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        do_vec("rem -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        do_vec("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        do_vec("rem 7/-2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
        do_vec("div by0", OP_DIV, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1);
        do_vec("divu by0", OP_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1);
        do_vec("rem by0", OP_REM, 32'h1234_5678, 32'd0, 32'h1234_5678, 1);
        do_vec("remu by0", OP_REMU, 32'h1234_5678, 32'd0, 32'h1234_5678, 1);
        do_vec("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_vec("rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        do_vec("divu ovf-ops", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
        do_vec("remu ovf-ops", OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
        do_vec("divu bigdiv", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 33);
        do_vec("remu bigdiv", OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33);
        do_vec("div min/1", OP_DIV, 32'h8000_0000, 32'd1, 32'h8000_0000, 33);

        // Stray start during CALC must be ignored
        run_op(OP_DIVU, 32'd100, 32'd7, 5, res, lat, nbusy);
        check("midcalc result", res, 32'd14);
        check("midcalc latency", 32'(lat), 32'd33);

        // Back-to-back: each run_op raises start in the DONE cycle of the previous one
        run_op(OP_REMU, 32'd100, 32'd7, 0, res, lat, nbusy);
        check("b2b1 result", res, 32'd2);
        check("b2b1 latency", 32'(lat), 32'd33);
        run_op(OP_DIV, 32'h1234_5678, 32'd0, 0, res, lat, nbusy);
        check("b2b2 result", res, 32'hFFFF_FFFF);
        check("b2b2 latency", 32'(lat), 32'd1);
        run_op(OP_REM, 32'h1234_5678, 32'd0, 0, res, lat, nbusy);
        check("b2b3 result", res, 32'h1234_5678);
        check("b2b3 latency", 32'(lat), 32'd1);
        run_op(OP_DIVU, 32'd1000, 32'd10, 0, res, lat, nbusy);
        check("b2b4 result", res, 32'd100);
        check("b2b4 latency", 32'(lat), 32'd33);
        @(posedge clk_i); #1;

        // Asynchronous reset at cycle 10 of a DIVU
        op_type_i = OP_DIVU; operand_a_i = 32'hFFFF; operand_b_i = 32'd3; start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
        repeat (9) begin @(posedge clk_i); #1; end
        check("pre-rst busy", 32'(busy_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        check("arst busy", 32'(busy_o), 32'd0);
        check("arst done", 32'(done_o), 32'd0);
        check("arst result", result_o, 32'd0);
        @(posedge clk_i); #1 rst_ni = 1'b1;
        n_done = 0;
        repeat (40) begin @(posedge clk_i); #1; if (done_o || busy_o) n_done++; end
        check("no done after rst", 32'(n_done), 32'd0);
        do_vec("post-rst divu", OP_DIVU, 32'hFFFF, 32'd3, 32'h5555, 33);

        // Random operands against a reference built from native division
        for (int i = 0; i < 200; i++) begin
            op = {1'b1, 2'($urandom_range(0, 3))};
            a = pick();
            b = pick();
            exp = model(op, a, b);
            exp_lat = (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
            run_op(op, a, b, 0, res, lat, nbusy);
            check($sformatf("rand%0d op%0d %h/%h", i, op[1:0], a, b), res, exp);
            check($sformatf("rand%0d latency", i), 32'(lat), 32'(exp_lat));
            if ($urandom_range(0, 1) == 1) begin @(posedge clk_i); #1; end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
